// File: rtl/cpu_pkg.sv
// Shared CPU types and constants: reset PC default, NOP encoding,
// fetch FSM states and the IF/ID bundle.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  typedef enum logic {
    RUN,
    HALT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{
    instr: NOP_INSTR,
    pc:    32'h0,
    pc4:   32'h0,
    valid: 1'b0
  };

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble wins over load, otherwise holds.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   load_i,
  input  logic   bubble_i,
  input  if_id_t data_i,
  output if_id_t q_o
);

  if_id_t q_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || bubble_i) begin
      q_q <= IF_ID_BUBBLE;
    end else if (load_i) begin
      q_q <= data_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/if_stage.sv
// Fetch stage: PC, RUN/HALT FSM, IF/ID register and optional
// performance counters (enabled by IF_STAGE_PERF_CNT_EN).
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  input  logic        resume,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic        halted,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  localparam logic [31:0] PC_RST = {RESET_PC[31:2], 2'b00};

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  tgt_pc;
  logic         load;
  logic         bubble;
  if_id_t       id_d, id_q;

  assign pc_plus4 = pc_q + 32'd4;
  assign tgt_pc   = {redirect_pc[31:2], 2'b00};

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    load    = 1'b0;
    bubble  = 1'b0;
    unique case (state_q)
      RUN: begin
        priority case (1'b1)
          halt: begin
            pc_d    = redirect ? tgt_pc : pc_q;
            bubble  = 1'b1;
            state_d = HALT;
          end
          redirect: begin
            pc_d   = tgt_pc;
            bubble = 1'b1;
          end
          flush: begin
            pc_d   = pc_plus4;
            bubble = 1'b1;
          end
          stall: ;
          default: begin
            pc_d = pc_plus4;
            load = 1'b1;
          end
        endcase
      end
      HALT: begin
        bubble = 1'b1;
        if (resume) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= PC_RST;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  assign id_d = '{
    instr: imem_rdata,
    pc:    pc_q,
    pc4:   pc_plus4,
    valid: 1'b1
  };

  if_id_reg u_if_id (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (load),
    .bubble_i(bubble),
    .data_i  (id_d),
    .q_o     (id_q)
  );

  assign imem_addr = pc_q;
  assign id_instr  = id_q.instr;
  assign id_pc     = id_q.pc;
  assign id_pc4    = id_q.pc4;
  assign id_valid  = id_q.valid;
  assign halted    = (state_q == HALT);

`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] fcnt_q, scnt_q;
  logic        stall_ev;

  // stall only counts when it is the rule actually applied in RUN
  assign stall_ev = (state_q == RUN) && stall &&
                    !halt && !redirect && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      if (load && fcnt_q != '1) fcnt_q <= fcnt_q + 32'd1;
      if (stall_ev && scnt_q != '1) scnt_q <= scnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fcnt_q;
  assign stall_cnt = scnt_q;
`else
  assign fetch_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: driver queues expected post-edge
// snapshots, a negedge monitor pops and compares them.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, redirect, halt, resume;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] id_instr, id_pc, id_pc4;
  logic        id_valid, halted;
  logic [31:0] fetch_cnt, stall_cnt;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        hlt;
    logic [31:0] fc;
    logic [31:0] sc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = 32'hC0DE_0000 | {16'h0, imem_addr[15:0]};

  if_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .resume     (resume),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_pc4     (id_pc4),
    .id_valid   (id_valid),
    .halted     (halted),
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt)
  );

  task automatic chk(input string nm, input int cyc,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  int mcyc = 0;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      mcyc++;
      chk("imem_addr", mcyc, imem_addr, e.addr);
      chk("id_instr", mcyc, id_instr, e.instr);
      chk("id_pc", mcyc, id_pc, e.pc);
      chk("id_pc4", mcyc, id_pc4, e.valid ? e.pc + 32'd4 : 32'h0);
      chk("id_valid", mcyc, {31'h0, id_valid}, {31'h0, e.valid});
      chk("halted", mcyc, {31'h0, halted}, {31'h0, e.hlt});
      chk("fetch_cnt", mcyc, fetch_cnt, e.fc);
      chk("stall_cnt", mcyc, stall_cnt, e.sc);
    end
  end

  task automatic step(
    input logic r, s, f, rd, input logic [31:0] rp,
    input logic h, rs,
    input logic [31:0] ea, ei, ep, input logic ev, eh,
    input logic [31:0] efc, esc);
    exp_t e;
    rst = r; stall = s; flush = f; redirect = rd;
    redirect_pc = rp; halt = h; resume = rs;
`ifndef IF_STAGE_PERF_CNT_EN
    efc = 0;
    esc = 0;
`endif
    e = '{addr: ea, instr: ei, pc: ep, valid: ev,
          hlt: eh, fc: efc, sc: esc};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // r s f rd rpc          h rs | addr         instr        pc           v h fc sc
    step(1,0,0,0,32'h0,        0,0, 32'h0,        32'h0,        32'h0,       0,0,0,0);
    step(1,1,1,1,32'h80,       1,1, 32'h0,        32'h0,        32'h0,       0,0,0,0);
    step(0,0,0,0,32'h0,        0,0, 32'h4,        32'hC0DE0000, 32'h0,       1,0,1,0);
    step(0,0,0,0,32'h0,        0,0, 32'h8,        32'hC0DE0004, 32'h4,       1,0,2,0);
    step(0,1,0,0,32'h0,        0,0, 32'h8,        32'hC0DE0004, 32'h4,       1,0,2,1);
    step(0,1,0,0,32'h0,        0,0, 32'h8,        32'hC0DE0004, 32'h4,       1,0,2,2);
    step(0,0,0,0,32'h0,        0,0, 32'hC,        32'hC0DE0008, 32'h8,       1,0,3,2);
    step(0,0,0,1,32'h43,       0,0, 32'h40,       32'h0,        32'h0,       0,0,3,2);
    step(0,0,0,0,32'h0,        0,0, 32'h44,       32'hC0DE0040, 32'h40,      1,0,4,2);
    step(0,0,0,0,32'h0,        0,0, 32'h48,       32'hC0DE0044, 32'h44,      1,0,5,2);
    step(0,0,1,0,32'h0,        0,0, 32'h4C,       32'h0,        32'h0,       0,0,5,2);
    step(0,0,0,0,32'h0,        0,0, 32'h50,       32'hC0DE004C, 32'h4C,      1,0,6,2);
    step(0,0,0,0,32'h0,        1,0, 32'h50,       32'h0,        32'h0,       0,1,6,2);
    step(0,1,1,1,32'h100,      1,0, 32'h50,       32'h0,        32'h0,       0,1,6,2);
    step(0,0,0,0,32'h0,        0,1, 32'h50,       32'h0,        32'h0,       0,0,6,2);
    step(0,0,0,0,32'h0,        0,0, 32'h54,       32'hC0DE0050, 32'h50,      1,0,7,2);
    step(0,0,0,1,32'h202,      1,0, 32'h200,      32'h0,        32'h0,       0,1,7,2);
    step(0,0,0,0,32'h0,        0,1, 32'h200,      32'h0,        32'h0,       0,0,7,2);
    step(0,0,0,0,32'h0,        0,0, 32'h204,      32'hC0DE0200, 32'h200,     1,0,8,2);
    step(0,0,0,1,32'hFFFFFFFE, 0,0, 32'hFFFFFFFC, 32'h0,        32'h0,       0,0,8,2);
    step(0,0,0,0,32'h0,        0,0, 32'h0,        32'hC0DEFFFC, 32'hFFFFFFFC,1,0,9,2);
    step(0,1,1,1,32'h10,       0,0, 32'h10,       32'h0,        32'h0,       0,0,9,2);
    step(0,1,1,0,32'h0,        0,0, 32'h14,       32'h0,        32'h0,       0,0,9,2);
    step(0,1,0,0,32'h0,        0,0, 32'h14,       32'h0,        32'h0,       0,0,9,3);
    step(0,0,0,0,32'h0,        0,0, 32'h18,       32'hC0DE0014, 32'h14,      1,0,10,3);
    step(0,1,0,0,32'h0,        0,0, 32'h18,       32'hC0DE0014, 32'h14,      1,0,10,4);
    step(1,1,0,0,32'h0,        0,0, 32'h0,        32'h0,        32'h0,       0,0,0,0);
    step(0,0,0,0,32'h0,        0,0, 32'h4,        32'hC0DE0000, 32'h0,       1,0,1,0);
    step(0,0,0,0,32'h0,        1,0, 32'h4,        32'h0,        32'h0,       0,1,1,0);
    step(1,0,0,0,32'h0,        1,0, 32'h0,        32'h0,        32'h0,       0,0,0,0);
    step(0,0,0,0,32'h0,        0,0, 32'h4,        32'hC0DE0000, 32'h0,       1,0,1,0);
    rst = 0; stall = 0; flush = 0; redirect = 0; halt = 0; resume = 0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
